i2c_target_byte: RTL and testbench

I2C_TARGET_BYTE -- requirements
Module: i2c_target_byte

---
 rtl/i2c_target_byte_pkg.sv | 26 ++
 rtl/i2c_target_byte_if.sv | 24 ++
 rtl/i2c_target_byte_line_filter.sv | 65 ++++++
 rtl/i2c_target_byte.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_target_byte.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_byte_pkg.sv
// Shared I2C definitions for the byte-level I2C target: FSM state encoding,
// bus constants and a small SDA drive helper.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Open-drain: a 0 on the bus means pull low, a 1 means release.
    function automatic logic drive_low(input logic bit_val);
        return (bit_val == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_target_byte_if.sv
// Application-side handshake of the I2C target: received bytes, transmit data
// request, and transfer status pulses.
interface i2c_target_byte_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       rw;
    logic       nack_seen;
    logic       stop_det;

    modport slave (
        output rx_data, rx_valid, tx_req, busy, rw, nack_seen, stop_det,
        input  tx_data
    );

    modport master (
        input  rx_data, rx_valid, tx_req, busy, rw, nack_seen, stop_det,
        output tx_data
    );

endinterface

// File: rtl/i2c_target_byte_line_filter.sv
// 2-FF synchronizer for one I2C line, followed by a FILTER_LEN-sample glitch
// filter when I2C_TARGET_GLITCH_FILTER_EN is defined.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q, sync_d;

    if (FILTER_LEN < 1) begin : g_len_check
        $error("i2c_line_filter: FILTER_LEN must be at least 1");
    end

    always_comb begin
        sync_d = {sync_q[0], din};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Count consecutive samples that disagree with the output; any agreeing
    // sample restarts the count, so a short spike never reaches dout.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_byte.sv
// Byte-oriented I2C target with 7-bit address ADDR. Optional line glitch
// filter selected by the I2C_TARGET_GLITCH_FILTER_EN macro.
module i2c_target_byte
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR       = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scl,
    inout  wire                sda,
    i2c_target_byte_if.slave   app
);

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
    logic       busy_q, busy_d, rw_q, rw_d;
    logic       nack_seen_q, nack_seen_d, stop_det_q, stop_det_d;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(clk), .reset_n(reset_n), .din(scl), .dout(scl_s)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(clk), .reset_n(reset_n), .din(sda), .dout(sda_s)
    );

    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_cond = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_cond  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // byte_done marks "8th bit (or master ACK) seen, act on the next SCL fall",
    // which keeps every SDA change in the low phase of SCL.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        busy_d      = busy_q;
        rw_d        = rw_q;
        nack_seen_d = 1'b0;
        stop_det_d  = 1'b0;

        if (stop_cond) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            stop_det_d  = 1'b1;
            byte_done_d = 1'b0;
        end else if (start_cond) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd7;
            sda_oe_d    = 1'b0;
            byte_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 3'd0) begin
                            byte_done_d = 1'b1;
                            if (shift_q[6:0] == ADDR) begin
                                busy_d = 1'b1;
                                rw_d   = sda_s;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (shift_q[7:1] == ADDR) begin
                            sda_oe_d = drive_low(ACK);
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise) begin
                        if (rw_q == RW_READ) tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = 3'd7;
                        if (rw_q == RW_WRITE) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_BYTE;
                        end else begin
                            shift_d  = app.tx_data;
                            sda_oe_d = drive_low(app.tx_data[7]);
                            state_d  = ST_RD_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 3'd0) begin
                            byte_done_d = 1'b1;
                            rx_data_d   = {shift_q[6:0], sda_s};
                            rx_valid_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = drive_low(ACK);
                        state_d     = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd7;
                        state_d   = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = drive_low(shift_q[6]);
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            nack_seen_d = 1'b1;
                            state_d     = ST_WAIT_STOP;
                        end else begin
                            tx_req_d    = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd7;
                        shift_d     = app.tx_data;
                        sda_oe_d    = drive_low(app.tx_data[7]);
                        state_d     = ST_RD_BYTE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd7;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            nack_seen_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            nack_seen_q <= nack_seen_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign sda           = sda_oe_q ? 1'b0 : 1'bz;
    assign app.rx_data   = rx_data_q;
    assign app.rx_valid  = rx_valid_q;
    assign app.tx_req    = tx_req_q;
    assign app.busy      = busy_q;
    assign app.rw        = rw_q;
    assign app.nack_seen = nack_seen_q;
    assign app.stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target_byte.sv
// Bit-banged I2C master exercising i2c_target_byte with directed and random
// transfers checked against a transaction-level expectation model.
module tb_i2c_target_byte;
    import i2c_pkg::*;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int         Q    = 12;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic scl       = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    int tests_run    = 0;
    int tests_failed = 0;
    int rx_valid_cnt = 0;
    int tx_req_cnt   = 0;
    int nack_cnt     = 0;
    int stop_cnt     = 0;
    int dut_low_cnt  = 0;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_byte_if app_if ();

    i2c_target_byte #(.ADDR(ADDR), .FILTER_LEN(3)) dut (
        .clk(clk), .reset_n(reset_n), .scl(scl), .sda(sda), .app(app_if.slave)
    );

    always #5 clk = ~clk;

    // Pulse counters and a record of any cycle where the target alone pulls SDA low.
    always @(negedge clk) begin
        if (app_if.rx_valid)  rx_valid_cnt++;
        if (app_if.tx_req)    tx_req_cnt++;
        if (app_if.nack_seen) nack_cnt++;
        if (app_if.stop_det)  stop_cnt++;
        if (sda === 1'b0 && !m_sda_low) dut_low_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic out_bit, output logic in_bit);
        m_sda_low = (out_bit == 1'b0);
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        in_bit = sda;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b1; wait_clk(Q);
        scl = 1'b0;       wait_clk(Q);
    endtask

    task automatic i2c_rstart();
        m_sda_low = 1'b0; wait_clk(Q);
        scl = 1'b1;       wait_clk(Q);
        m_sda_low = 1'b1; wait_clk(Q);
        scl = 1'b0;       wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_clk(Q);
        scl = 1'b1;       wait_clk(Q);
        m_sda_low = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic ign;
        for (int i = 7; i >= 0; i--) apply_stimulus(b[i], ign);
        apply_stimulus(1'b1, ack);
    endtask

    task automatic read_bits(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) apply_stimulus(1'b1, b[i]);
    endtask

    initial begin
        logic       ack, ign, match;
        logic [7:0] b, exp_rx;
        logic [6:0] addr;
        logic [7:0] q[$];
        int         n, base_rxv, base_txr, base_nack, base_stop, base_low;

        app_if.tx_data = 8'h00;
        exp_rx = 8'h00;
        wait_clk(5);
        check_output("rst_rx_data", app_if.rx_data, 8'h00);
        check_output("rst_rx_valid", app_if.rx_valid, 1'b0);
        check_output("rst_tx_req", app_if.tx_req, 1'b0);
        check_output("rst_busy", app_if.busy, 1'b0);
        check_output("rst_rw", app_if.rw, 1'b0);
        check_output("rst_nack_stop", {app_if.nack_seen, app_if.stop_det}, 2'b00);
        check_output("rst_sda", sda, 1'b1);
        reset_n = 1'b1;
        wait_clk(5);

        // Basic write of 0xA5.
        base_rxv = rx_valid_cnt; base_stop = stop_cnt;
        i2c_start();
        write_byte({ADDR, RW_WRITE}, ack);
        check_output("wr_addr_ack", ack, ACK);
        write_byte(8'hA5, ack);
        check_output("wr_data_ack", ack, ACK);
        check_output("wr_busy", app_if.busy, 1'b1);
        check_output("wr_rw", app_if.rw, RW_WRITE);
        i2c_stop();
        exp_rx = 8'hA5;
        check_output("wr_rx_data", app_if.rx_data, exp_rx);
        check_output("wr_rx_valid_cnt", rx_valid_cnt - base_rxv, 1);
        check_output("wr_stop_cnt", stop_cnt - base_stop, 1);
        check_output("wr_busy_after_stop", app_if.busy, 1'b0);

        // Wrong address: target must stay silent.
        base_rxv = rx_valid_cnt; base_stop = stop_cnt; base_low = dut_low_cnt;
        i2c_start();
        write_byte({7'h43, RW_WRITE}, ack);
        check_output("miss_addr_ack", ack, NACK);
        write_byte(8'hFF, ack);
        check_output("miss_data_ack", ack, NACK);
        check_output("miss_busy", app_if.busy, 1'b0);
        i2c_stop();
        check_output("miss_sda_driven", dut_low_cnt - base_low, 0);
        check_output("miss_rx_valid_cnt", rx_valid_cnt - base_rxv, 0);
        check_output("miss_stop_cnt", stop_cnt - base_stop, 1);
        check_output("miss_rx_data", app_if.rx_data, exp_rx);

        // Random write transfers, matched or not.
        for (int t = 0; t < 4; t++) begin
            match = ($urandom_range(0, 1) == 1);
            addr  = 7'($urandom);
            if (match) addr = ADDR;
            else if (addr == ADDR) addr = addr ^ 7'h01;
            n = $urandom_range(1, 3);
            base_rxv = rx_valid_cnt; base_low = dut_low_cnt;
            i2c_start();
            write_byte({addr, RW_WRITE}, ack);
            check_output("rnd_wr_addr_ack", ack, match ? ACK : NACK);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                write_byte(b, ack);
                check_output("rnd_wr_data_ack", ack, match ? ACK : NACK);
                if (match) exp_rx = b;
            end
            i2c_stop();
            check_output("rnd_wr_rx_data", app_if.rx_data, exp_rx);
            check_output("rnd_wr_rx_valid_cnt", rx_valid_cnt - base_rxv, match ? n : 0);
            if (!match) check_output("rnd_wr_silent", dut_low_cnt - base_low, 0);
        end

        // Read 0x3C then 0xC3 with master ACK then NACK.
        base_txr = tx_req_cnt; base_nack = nack_cnt;
        app_if.tx_data = 8'h3C;
        i2c_start();
        write_byte({ADDR, RW_READ}, ack);
        check_output("rd_addr_ack", ack, ACK);
        read_bits(b);
        check_output("rd_byte0", b, 8'h3C);
        app_if.tx_data = 8'hC3;
        apply_stimulus(ACK, ign);
        read_bits(b);
        check_output("rd_byte1", b, 8'hC3);
        apply_stimulus(NACK, ign);
        check_output("rd_tx_req_cnt", tx_req_cnt - base_txr, 2);
        check_output("rd_nack_cnt", nack_cnt - base_nack, 1);
        check_output("rd_rw", app_if.rw, RW_READ);
        base_low = dut_low_cnt;
        read_bits(b);
        check_output("rd_wait_stop_silent", dut_low_cnt - base_low, 0);
        check_output("rd_busy_before_stop", app_if.busy, 1'b1);
        i2c_stop();
        check_output("rd_busy_after_stop", app_if.busy, 1'b0);

        // Random multi-byte reads.
        for (int t = 0; t < 3; t++) begin
            q.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            base_txr = tx_req_cnt; base_nack = nack_cnt;
            app_if.tx_data = q[0];
            i2c_start();
            write_byte({ADDR, RW_READ}, ack);
            check_output("rnd_rd_addr_ack", ack, ACK);
            for (int k = 0; k < n; k++) begin
                read_bits(b);
                check_output("rnd_rd_byte", b, q[k]);
                if (k < n - 1) begin
                    app_if.tx_data = q[k + 1];
                    apply_stimulus(ACK, ign);
                end else begin
                    apply_stimulus(NACK, ign);
                end
            end
            i2c_stop();
            check_output("rnd_rd_tx_req_cnt", tx_req_cnt - base_txr, n);
            check_output("rnd_rd_nack_cnt", nack_cnt - base_nack, 1);
        end

        // Write then repeated START into a read.
        i2c_start();
        write_byte({ADDR, RW_WRITE}, ack);
        write_byte(8'h01, ack);
        check_output("rs_wr_ack", ack, ACK);
        check_output("rs_rw_before", app_if.rw, RW_WRITE);
        i2c_rstart();
        check_output("rs_busy_after_rstart", app_if.busy, 1'b1);
        app_if.tx_data = 8'h80;
        write_byte({ADDR, RW_READ}, ack);
        check_output("rs_rd_addr_ack", ack, ACK);
        check_output("rs_rw_after", app_if.rw, RW_READ);
        check_output("rs_busy_during_read", app_if.busy, 1'b1);
        read_bits(b);
        check_output("rs_first_bit", b[7], 1'b1);
        check_output("rs_rd_byte", b, 8'h80);
        apply_stimulus(NACK, ign);
        i2c_stop();
        exp_rx = 8'h01;
        check_output("rs_rx_data", app_if.rx_data, exp_rx);

        // Reset while the target is driving bit 4 of a read byte.
        base_rxv = rx_valid_cnt;
        app_if.tx_data = 8'h00;
        i2c_start();
        write_byte({ADDR, RW_READ}, ack);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, ign);
        m_sda_low = 1'b0;
        wait_clk(Q);
        check_output("rr_dut_driving", sda, 1'b0);
        reset_n = 1'b0;
        #1;
        check_output("rr_sda_released", sda, 1'b1);
        check_output("rr_busy", app_if.busy, 1'b0);
        check_output("rr_rx_data", app_if.rx_data, 8'h00);
        wait_clk(3);
        scl = 1'b1;
        wait_clk(Q);
        reset_n = 1'b1;
        wait_clk(Q);
        check_output("rr_rx_valid_cnt", rx_valid_cnt - base_rxv, 0);
        b = 8'($urandom);
        i2c_start();
        write_byte({ADDR, RW_WRITE}, ack);
        check_output("rr_post_addr_ack", ack, ACK);
        write_byte(b, ack);
        check_output("rr_post_data_ack", ack, ACK);
        i2c_stop();
        check_output("rr_post_rx_data", app_if.rx_data, b);

        // One-cycle SDA spike while SCL is high on an idle bus.
        base_stop = stop_cnt;
        m_sda_low = 1'b1;
        wait_clk(1);
        m_sda_low = 1'b0;
        wait_clk(Q + 10);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check_output("spike_stop_cnt", stop_cnt - base_stop, 0);
`else
        check_output("spike_stop_cnt", stop_cnt - base_stop, 1);
`endif
        check_output("spike_busy", app_if.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
